// File: rtl/sram_pkg.sv
// ---------------------------------------------------------------------------
// sram_pkg
// Shared definitions for the sram_1w2r RAM and its write-first front-end.
//   sram_clr_e   : state of the post-reset clear sweep
//   sram_addr_w  : address width for a given entry count (at least 1 bit)
// ---------------------------------------------------------------------------
package sram_pkg;

  typedef enum logic {
    SRAM_CLR_CLEAR = 1'b0,
    SRAM_CLR_READY = 1'b1
  } sram_clr_e;

  // Usable in localparams and port widths; DEPTH need not be a power of two.
  function automatic int sram_addr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/sram_1w2r.sv
// ---------------------------------------------------------------------------
// sram_1w2r
// Behavioural 1-write / 2-read block RAM with registered read ports.
// A read of the address being written in the same cycle returns the OLD
// contents, matching typical block-RAM primitives in read-first mode.
// INIT names a hex preload image consumed by the FPGA implementation flow;
// this model leaves contents undefined until written.
// Ports:
//   i_clk                      clock, rising edge
//   i_w_e / i_w_addr / i_w_data write port
//   i_r0_e / i_r0_addr          read port 0 request
//   i_r1_e / i_r1_addr          read port 1 request
//   o_r0_data / o_r1_data       registered read data, held while enable low
// ---------------------------------------------------------------------------
module sram_1w2r
  import sram_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter     INIT  = "",
  localparam int AW   = sram_addr_w(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_w_e,
  input  logic [AW-1:0]    i_w_addr,
  input  logic [WIDTH-1:0] i_w_data,
  input  logic             i_r0_e,
  input  logic [AW-1:0]    i_r0_addr,
  input  logic             i_r1_e,
  input  logic [AW-1:0]    i_r1_addr,
  output logic [WIDTH-1:0] o_r0_data,
  output logic [WIDTH-1:0] o_r1_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_r0_q;
  logic [WIDTH-1:0] r_r1_q;

  // Non-blocking update gives read-first behaviour on an address collision.
  always_ff @(posedge i_clk) begin
    if (i_w_e) r_mem[i_w_addr] <= i_w_data;
    if (i_r0_e) r_r0_q <= r_mem[i_r0_addr];
    if (i_r1_e) r_r1_q <= r_mem[i_r1_addr];
  end

  assign o_r0_data = r_r0_q;
  assign o_r1_data = r_r1_q;

endmodule

// File: rtl/sram_1w2r_fwd.sv
// ---------------------------------------------------------------------------
// sram_1w2r_fwd
// Read-side front-end for sram_1w2r giving write-first semantics: a read of
// the address written in the same cycle returns the new data on either port.
// Read outputs are zero until each port's first enabled read after reset.
// Optional macro SRAM_1W2R_FWD_CLEAR_EN compiles in a sweep that zeroes the
// whole array after reset; o_ready stays low (and all external requests are
// ignored) until the sweep is done. Without it o_ready is tied high.
// Ports:
//   i_clk, i_rst                clock, async active-high reset
//   i_w_e / i_w_addr / i_w_data write port
//   i_r0_e / i_r0_addr          read port 0 request
//   i_r1_e / i_r1_addr          read port 1 request
//   o_r0_data / o_r1_data       read data, 1-cycle latency, held when idle
//   o_ready                     block accepts reads and writes
// ---------------------------------------------------------------------------
module sram_1w2r_fwd
  import sram_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter     INIT  = "",
  localparam int AW   = sram_addr_w(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_w_e,
  input  logic [AW-1:0]    i_w_addr,
  input  logic [WIDTH-1:0] i_w_data,
  input  logic             i_r0_e,
  input  logic [AW-1:0]    i_r0_addr,
  input  logic             i_r1_e,
  input  logic [AW-1:0]    i_r1_addr,
  output logic [WIDTH-1:0] o_r0_data,
  output logic [WIDTH-1:0] o_r1_data,
  output logic             o_ready
);

  logic             w_ready;
  logic             w_ram_we;
  logic [AW-1:0]    w_ram_waddr;
  logic [WIDTH-1:0] w_ram_wdata;
  logic [WIDTH-1:0] w_ram_r0;
  logic [WIDTH-1:0] w_ram_r1;

`ifdef SRAM_1W2R_FWD_CLEAR_EN
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam                RAM_INIT  = "";

  sram_clr_e     r_state;
  sram_clr_e     w_state_next;
  logic [AW-1:0] r_clr_cnt;
  logic [AW-1:0] w_clr_cnt_next;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= SRAM_CLR_CLEAR;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_state_next;
      r_clr_cnt <= w_clr_cnt_next;
    end
  end

  // While clearing, the sweep owns the RAM write port outright.
  always_comb begin
    w_state_next   = r_state;
    w_clr_cnt_next = r_clr_cnt;
    w_ram_we       = i_w_e;
    w_ram_waddr    = i_w_addr;
    w_ram_wdata    = i_w_data;
    case (r_state)
      SRAM_CLR_CLEAR: begin
        w_ram_we    = 1'b1;
        w_ram_waddr = r_clr_cnt;
        w_ram_wdata = '0;
        if (r_clr_cnt == LAST_ADDR) begin
          w_state_next = SRAM_CLR_READY;
        end else begin
          w_clr_cnt_next = r_clr_cnt + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Pure decode of the state register, so no input reaches o_ready.
  assign w_ready = (r_state == SRAM_CLR_READY);
`else
  localparam RAM_INIT = INIT;

  assign w_ready     = 1'b1;
  assign w_ram_we    = i_w_e;
  assign w_ram_waddr = i_w_addr;
  assign w_ram_wdata = i_w_data;
`endif

  logic w_ext_we;
  logic w_r0_e;
  logic w_r1_e;

  assign w_ext_we = w_ready & i_w_e;
  assign w_r0_e   = w_ready & i_r0_e;
  assign w_r1_e   = w_ready & i_r1_e;

  sram_1w2r #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .INIT  (RAM_INIT)
  ) u_ram (
    .i_clk     (i_clk),
    .i_w_e     (w_ram_we),
    .i_w_addr  (w_ram_waddr),
    .i_w_data  (w_ram_wdata),
    .i_r0_e    (w_r0_e),
    .i_r0_addr (i_r0_addr),
    .i_r1_e    (w_r1_e),
    .i_r1_addr (i_r1_addr),
    .o_r0_data (w_ram_r0),
    .o_r1_data (w_ram_r1)
  );

  logic             r_v0, r_v1;
  logic             r_f0, r_f1;
  logic [WIDTH-1:0] r_d0, r_d1;
  logic             w_hit0, w_hit1;

  assign w_hit0 = w_ext_we & (i_w_addr == i_r0_addr);
  assign w_hit1 = w_ext_we & (i_w_addr == i_r1_addr);

  // Capture a same-cycle write so it can override the RAM's stale read data.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_v0 <= 1'b0;
      r_f0 <= 1'b0;
      r_d0 <= '0;
      r_v1 <= 1'b0;
      r_f1 <= 1'b0;
      r_d1 <= '0;
    end else begin
      if (w_r0_e) begin
        r_v0 <= 1'b1;
        r_f0 <= w_hit0;
        if (w_hit0) r_d0 <= i_w_data;
      end
      if (w_r1_e) begin
        r_v1 <= 1'b1;
        r_f1 <= w_hit1;
        if (w_hit1) r_d1 <= i_w_data;
      end
    end
  end

  assign o_r0_data = !r_v0 ? '0 : (r_f0 ? r_d0 : w_ram_r0);
  assign o_r1_data = !r_v1 ? '0 : (r_f1 ? r_d1 : w_ram_r1);
  assign o_ready   = w_ready;

endmodule

// File: tb/tb_sram_1w2r_fwd.sv
// ---------------------------------------------------------------------------
// tb_sram_1w2r_fwd
// Directed bench for sram_1w2r_fwd (DEPTH=8 main instance, DEPTH=5 second
// instance). Follows SRAM_1W2R_FWD_CLEAR_EN so the same file serves both
// builds.
// ---------------------------------------------------------------------------
module tb_sram_1w2r_fwd;

  localparam int WIDTH  = 32;
  localparam int DEPTH  = 8;
  localparam int AW     = 3;
  localparam int DEPTH5 = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst = 1'b1;
  logic             w_e = 1'b0;
  logic [AW-1:0]    w_addr = '0;
  logic [WIDTH-1:0] w_data = '0;
  logic             r0_e = 1'b0, r1_e = 1'b0;
  logic [AW-1:0]    r0_addr = '0, r1_addr = '0;
  logic [WIDTH-1:0] r0_data, r1_data;
  logic             ready;

  logic             rst5 = 1'b1;
  logic             w_e5 = 1'b0;
  logic [AW-1:0]    w_addr5 = '0;
  logic [WIDTH-1:0] w_data5 = '0;
  logic             r0_e5 = 1'b0, r1_e5 = 1'b0;
  logic [AW-1:0]    r0_addr5 = '0, r1_addr5 = '0;
  logic [WIDTH-1:0] r0_data5, r1_data5;
  logic             ready5;

  int nVectors = 0;
  int nFail    = 0;
  int badWrites5 = 0;

  sram_1w2r_fwd #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_w_e(w_e), .i_w_addr(w_addr), .i_w_data(w_data),
    .i_r0_e(r0_e), .i_r0_addr(r0_addr),
    .i_r1_e(r1_e), .i_r1_addr(r1_addr),
    .o_r0_data(r0_data), .o_r1_data(r1_data), .o_ready(ready)
  );

  sram_1w2r_fwd #(.WIDTH(WIDTH), .DEPTH(DEPTH5)) dut5 (
    .i_clk(clk), .i_rst(rst5),
    .i_w_e(w_e5), .i_w_addr(w_addr5), .i_w_data(w_data5),
    .i_r0_e(r0_e5), .i_r0_addr(r0_addr5),
    .i_r1_e(r1_e5), .i_r1_addr(r1_addr5),
    .o_r0_data(r0_data5), .o_r1_data(r1_data5), .o_ready(ready5)
  );

  // Value presented to the RAM at the coming rising edge.
  always @(negedge clk) begin
    if (!rst5 && dut5.w_ram_we && (dut5.w_ram_waddr >= 3'(DEPTH5))) badWrites5++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    w_e = 1'b0; r0_e = 1'b0; r1_e = 1'b0;
  endtask

  task automatic test_reset();
    logic expReady;
    rst = 1'b1; r0_addr = 3'd0; r1_addr = 3'd1;
`ifdef SRAM_1W2R_FWD_CLEAR_EN
    // Hostile traffic during the sweep must be ignored.
    w_e = 1'b1; w_data = 32'hFFFF_FFFF; r0_e = 1'b1; r1_e = 1'b1;
`else
    // No sweep: zero-fill the array by hand instead.
    w_e = 1'b1; w_data = 32'h0; r0_e = 1'b0; r1_e = 1'b0;
`endif
    tick(); tick();
    nVectors++;
    if (r0_data !== '0 || r1_data !== '0) begin
      nFail++; $display("[TB] FAIL reset_data: got %h/%h expected 0/0", r0_data, r1_data);
    end
`ifdef SRAM_1W2R_FWD_CLEAR_EN
    expReady = 1'b0;
`else
    expReady = 1'b1;
`endif
    nVectors++;
    if (ready !== expReady) begin
      nFail++; $display("[TB] FAIL reset_ready: got %b expected %b", ready, expReady);
    end
    rst = 1'b0;
    for (int k = 1; k <= DEPTH; k++) begin
      w_addr = 3'(k - 1);
      tick();
`ifdef SRAM_1W2R_FWD_CLEAR_EN
      expReady = (k == DEPTH);
`else
      expReady = 1'b1;
`endif
      nVectors++;
      if (ready !== expReady) begin
        nFail++; $display("[TB] FAIL sweep_ready[%0d]: got %b expected %b", k, ready, expReady);
      end
      nVectors++;
      if (r0_data !== '0 || r1_data !== '0) begin
        nFail++; $display("[TB] FAIL sweep_data[%0d]: got %h/%h expected 0/0", k, r0_data, r1_data);
      end
    end
    idle();
    for (int a = 0; a < DEPTH; a++) begin
      r0_e = 1'b1; r0_addr = 3'(a);
      r1_e = 1'b1; r1_addr = 3'(DEPTH - 1 - a);
      tick();
      nVectors++;
      if (r0_data !== '0 || r1_data !== '0) begin
        nFail++; $display("[TB] FAIL readback_zero[%0d]: got %h/%h expected 0/0", a, r0_data, r1_data);
      end
    end
    idle();
  endtask

  task automatic test_forward();
    // Raw RAM would return the old 0 here; write-first must give the new value.
    w_e = 1'b1; w_addr = 3'd3; w_data = 32'hDEAD_BEEF;
    r0_e = 1'b1; r0_addr = 3'd3; r1_e = 1'b0;
    tick();
    nVectors++;
    if (r0_data !== 32'hDEAD_BEEF) begin
      nFail++; $display("[TB] FAIL fwd_r0: got %h expected DEADBEEF", r0_data);
    end
    nVectors++;
    if (r1_data !== 32'h0) begin
      nFail++; $display("[TB] FAIL fwd_r1_hold: got %h expected 00000000", r1_data);
    end
    w_addr = 3'd4; w_data = 32'hCAFE_F00D;
    r0_addr = 3'd3; r1_e = 1'b1; r1_addr = 3'd4;
    tick();
    nVectors++;
    if (r0_data !== 32'hDEAD_BEEF || r1_data !== 32'hCAFE_F00D) begin
      nFail++; $display("[TB] FAIL fwd_mixed: got %h/%h expected DEADBEEF/CAFEF00D", r0_data, r1_data);
    end
    w_e = 1'b0; r0_addr = 3'd4; r1_addr = 3'd3;
    tick();
    nVectors++;
    if (r0_data !== 32'hCAFE_F00D || r1_data !== 32'hDEAD_BEEF) begin
      nFail++; $display("[TB] FAIL fwd_ram_read: got %h/%h expected CAFEF00D/DEADBEEF", r0_data, r1_data);
    end
    idle();
  endtask

  task automatic test_dual_forward();
    w_e = 1'b1; w_addr = 3'd5; w_data = 32'h0000_1234;
    r0_e = 1'b1; r0_addr = 3'd5; r1_e = 1'b1; r1_addr = 3'd5;
    tick();
    nVectors++;
    if (r0_data !== 32'h0000_1234 || r1_data !== 32'h0000_1234) begin
      nFail++; $display("[TB] FAIL dual_fwd: got %h/%h expected 00001234/00001234", r0_data, r1_data);
    end
    // Matching address with write disabled must not forward.
    w_e = 1'b0; w_data = 32'hFFFF_FFFF;
    tick();
    nVectors++;
    if (r0_data !== 32'h0000_1234 || r1_data !== 32'h0000_1234) begin
      nFail++; $display("[TB] FAIL dual_no_we: got %h/%h expected 00001234/00001234", r0_data, r1_data);
    end
    idle();
  endtask

  task automatic test_hold();
    w_e = 1'b1; w_addr = 3'd2; w_data = 32'h0000_00A5;
    tick();
    w_e = 1'b0; r0_e = 1'b1; r0_addr = 3'd2;
    tick();
    nVectors++;
    if (r0_data !== 32'h0000_00A5) begin
      nFail++; $display("[TB] FAIL hold_first: got %h expected 000000A5", r0_data);
    end
    r0_e = 1'b0; w_e = 1'b1; w_addr = 3'd2; w_data = 32'h0000_005A;
    for (int k = 0; k < 4; k++) begin
      tick();
      nVectors++;
      if (r0_data !== 32'h0000_00A5) begin
        nFail++; $display("[TB] FAIL hold_cycle[%0d]: got %h expected 000000A5", k, r0_data);
      end
    end
    w_e = 1'b0; r0_e = 1'b1;
    tick();
    nVectors++;
    if (r0_data !== 32'h0000_005A) begin
      nFail++; $display("[TB] FAIL hold_reread: got %h expected 0000005A", r0_data);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    w_e = 1'b1; w_addr = 3'd6; w_data = 32'h0000_0077;
    tick();
    w_addr = 3'd1; w_data = 32'h0000_0099;
    r0_e = 1'b1; r0_addr = 3'd6; r1_e = 1'b1; r1_addr = 3'd1;
    tick();
    nVectors++;
    if (r0_data !== 32'h0000_0077 || r1_data !== 32'h0000_0099) begin
      nFail++; $display("[TB] FAIL b2b: got %h/%h expected 00000077/00000099", r0_data, r1_data);
    end
    idle();
  endtask

  task automatic test_mid_reset();
    logic expReady;
    rst = 1'b1;
    #1;
    nVectors++;
    if (r0_data !== '0 || r1_data !== '0) begin
      nFail++; $display("[TB] FAIL async_reset_data: got %h/%h expected 0/0", r0_data, r1_data);
    end
    tick();
    rst = 1'b0;
`ifdef SRAM_1W2R_FWD_CLEAR_EN
    for (int k = 1; k <= 4; k++) begin
      tick();
      nVectors++;
      if (ready !== 1'b0) begin
        nFail++; $display("[TB] FAIL midsweep_ready[%0d]: got %b expected 0", k, ready);
      end
    end
    rst = 1'b1;
    #1;
    nVectors++;
    if (ready !== 1'b0) begin
      nFail++; $display("[TB] FAIL abort_ready: got %b expected 0", ready);
    end
    tick();
    rst = 1'b0;
    for (int k = 1; k <= DEPTH; k++) begin
      tick();
      expReady = (k == DEPTH);
      nVectors++;
      if (ready !== expReady) begin
        nFail++; $display("[TB] FAIL resweep_ready[%0d]: got %b expected %b", k, ready, expReady);
      end
    end
    r0_e = 1'b1; r0_addr = 3'd6;
    tick();
    nVectors++;
    if (r0_data !== 32'h0) begin
      nFail++; $display("[TB] FAIL resweep_cleared: got %h expected 00000000", r0_data);
    end
`else
    expReady = 1'b1;
    tick();
    nVectors++;
    if (ready !== expReady) begin
      nFail++; $display("[TB] FAIL noclr_ready: got %b expected 1", ready);
    end
    r0_e = 1'b1; r0_addr = 3'd6;
    tick();
    nVectors++;
    if (r0_data !== 32'h0000_0077) begin
      nFail++; $display("[TB] FAIL retained_after_reset: got %h expected 00000077", r0_data);
    end
`endif
    idle();
  endtask

  task automatic test_depth5();
    rst5 = 1'b1;
    tick();
    rst5 = 1'b0;
`ifdef SRAM_1W2R_FWD_CLEAR_EN
    for (int k = 1; k <= DEPTH5; k++) begin
      tick();
      nVectors++;
      if (ready5 !== (k == DEPTH5)) begin
        nFail++; $display("[TB] FAIL d5_ready[%0d]: got %b expected %b", k, ready5, (k == DEPTH5));
      end
    end
    tick(); tick();
    nVectors++;
    if (badWrites5 !== 0) begin
      nFail++; $display("[TB] FAIL d5_out_of_range_writes: got %0d expected 0", badWrites5);
    end
`else
    tick();
    nVectors++;
    if (ready5 !== 1'b1) begin
      nFail++; $display("[TB] FAIL d5_ready: got %b expected 1", ready5);
    end
`endif
    w_e5 = 1'b1; w_addr5 = 3'd4; w_data5 = 32'h0000_0044;
    r0_e5 = 1'b1; r0_addr5 = 3'd4;
    tick();
    nVectors++;
    if (r0_data5 !== 32'h0000_0044) begin
      nFail++; $display("[TB] FAIL d5_fwd: got %h expected 00000044", r0_data5);
    end
    w_e5 = 1'b0; r0_e5 = 1'b0; r1_e5 = 1'b1; r1_addr5 = 3'd4;
    tick();
    nVectors++;
    if (r1_data5 !== 32'h0000_0044 || r0_data5 !== 32'h0000_0044) begin
      nFail++; $display("[TB] FAIL d5_read: got %h/%h expected 00000044/00000044", r0_data5, r1_data5);
    end
    r1_e5 = 1'b0;
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_forward();
    test_dual_forward();
    test_hold();
    test_back_to_back();
    test_mid_reset();
    test_depth5();
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nFail);
    $finish;
  end

endmodule
